// File: rtl/motion_search_ctrl.sv
// Full-search sequencer for one block-compare engine: walks the candidate window in raster order,
// feeds the running best SAD back as the early-termination threshold and records the winner.
module motion_search_ctrl #(
  parameter int R     = 4,
  parameter int ACC_W = 18
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    lim_l_i,
  input  logic                    lim_r_i,
  input  logic                    lim_t_i,
  input  logic                    lim_b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [4:0]       cand_dx_o,
  output logic signed [4:0]       cand_dy_o,
  output logic                    cmp_en_o,
  input  logic                    cmp_rdy_i,
  input  logic                    cmp_valid_i,
  input  logic [ACC_W-1:0]        cmp_accum_i,
  output logic [ACC_W-1:0]        cmp_oldaccum_o,
  output logic                    commit_o,
  output logic signed [4:0]       best_dx_o,
  output logic signed [4:0]       best_dy_o,
  output logic [ACC_W-1:0]        best_sad_o,
  output logic                    best_found_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_FIN     = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  localparam logic signed [4:0] POS_R    = 5'(R);
  localparam logic signed [4:0] NEG_R    = -POS_R;
  localparam logic signed [4:0] ZERO_V   = 5'sd0;
  localparam logic signed [4:0] ONE_V    = 5'sd1;
  localparam logic [ACC_W-1:0]  SAD_MAX  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0]  SAD_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0]  SAD_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic signed [4:0]     cand_dx_q, cand_dx_d;
  logic signed [4:0]     cand_dy_q, cand_dy_d;
  logic signed [4:0]     best_dx_q, best_dx_d;
  logic signed [4:0]     best_dy_q, best_dy_d;
  logic [ACC_W-1:0]      best_sad_q, best_sad_d;
  logic [ACC_W-1:0]      thr_q, thr_d;
  logic                  best_found_q, best_found_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmp_en_q, cmp_en_d;
  logic                  commit_q, commit_d;

  logic                  cand_skip;
  logic                  at_end;
  logic                  is_last;
  logic signed [4:0]     x_last;
  logic signed [4:0]     y_last;
  logic signed [4:0]     nxt_dx;
  logic signed [4:0]     nxt_dy;

  // Candidate window bookkeeping: frame-edge skips, raster advance, last-launchable detection
  always_comb begin
    cand_skip = (lim_l_i && (cand_dx_q < ZERO_V)) || (lim_r_i && (cand_dx_q > ZERO_V)) ||
                (lim_t_i && (cand_dy_q < ZERO_V)) || (lim_b_i && (cand_dy_q > ZERO_V));
    x_last    = lim_r_i ? ZERO_V : POS_R;
    y_last    = lim_b_i ? ZERO_V : POS_R;
    at_end    = (cand_dx_q == POS_R) && (cand_dy_q == POS_R);
    is_last   = at_end || ((cand_dx_q == x_last) && (cand_dy_q == y_last));
    if (cand_dx_q == POS_R) begin
      nxt_dx = NEG_R;
      nxt_dy = cand_dy_q + ONE_V;
    end else begin
      nxt_dx = cand_dx_q + ONE_V;
      nxt_dy = cand_dy_q;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    cand_dx_d    = cand_dx_q;
    cand_dy_d    = cand_dy_q;
    best_dx_d    = best_dx_q;
    best_dy_d    = best_dy_q;
    best_sad_d   = best_sad_q;
    thr_d        = thr_q;
    best_found_d = best_found_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cmp_en_d     = 1'b0;
    commit_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort beats a same-cycle start
        if (start_i && !abort_i) begin
          cand_dx_d    = NEG_R;
          cand_dy_d    = NEG_R;
          best_sad_d   = SAD_MAX;
          thr_d        = SAD_MAX;
          best_found_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (cand_skip) begin
          if (at_end) begin
            state_d = S_FIN;
          end else begin
            cand_dx_d = nxt_dx;
            cand_dy_d = nxt_dy;
            state_d   = S_SEL;
          end
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (cmp_rdy_i) begin
          cmp_en_d = 1'b1;
          state_d  = S_WAIT_LO;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_WAIT_LO: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (!cmp_rdy_i) begin
          state_d = S_WAIT_HI;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_HI: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (cmp_rdy_i) begin
          if (cmp_valid_i) begin
            best_sad_d   = cmp_accum_i;
            best_dx_d    = cand_dx_q;
            best_dy_d    = cand_dy_q;
            best_found_d = 1'b1;
            commit_d     = 1'b1;
            // the engine passes accum <= threshold, so threshold = best-1 keeps ties on the earlier vector
            thr_d        = (cmp_accum_i == SAD_ZERO) ? SAD_ZERO : (cmp_accum_i - SAD_ONE);
          end else begin
            commit_d = 1'b0;
          end
          if ((best_sad_d == SAD_ZERO) || is_last) begin
            state_d = S_FIN;
          end else begin
            cand_dx_d = nxt_dx;
            cand_dy_d = nxt_dy;
            state_d   = S_SEL;
          end
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_FIN: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cmp_rdy_i) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cand_dx_q    <= 5'sd0;
      cand_dy_q    <= 5'sd0;
      best_dx_q    <= 5'sd0;
      best_dy_q    <= 5'sd0;
      best_sad_q   <= SAD_MAX;
      thr_q        <= SAD_MAX;
      best_found_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmp_en_q     <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_dx_q    <= cand_dx_d;
      cand_dy_q    <= cand_dy_d;
      best_dx_q    <= best_dx_d;
      best_dy_q    <= best_dy_d;
      best_sad_q   <= best_sad_d;
      thr_q        <= thr_d;
      best_found_q <= best_found_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmp_en_q     <= cmp_en_d;
      commit_q     <= commit_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cand_dx_o      = cand_dx_q;
  assign cand_dy_o      = cand_dy_q;
  assign cmp_en_o       = cmp_en_q;
  assign cmp_oldaccum_o = thr_q;
  assign commit_o       = commit_q;
  assign best_dx_o      = best_dx_q;
  assign best_dy_o      = best_dy_q;
  assign best_sad_o     = best_sad_q;
  assign best_found_o   = best_found_q;

endmodule
